// File: rtl/map_switch.sv
// -----------------------------------------------------------------------------
// map_switch
//
// Switches the active cartridge mapper slot on a toggle request that arrives
// from another clock domain. A switch waits for the bus to go quiet,
// holds every mapper in reset for HOLD_CYCLES cycles, and then commits the new
// slot index, its arguments and the derived PRG mask / CHR base.
//
// Ports
//   clk           : clock, all logic on the rising edge
//   reset_n       : synchronous active-low reset
//   map_ctrl      : {args, select} of the requested mapper, stable while pending
//   map_ctrl_req  : toggle request (asynchronous to clk)
//   map_ctrl_ack  : toggle acknowledge, equals the request parity when idle
//   bus_busy      : the active mapper is driving prg_oe or chr_ce
//   select        : active mapper index
//   map_args      : active mapper arguments (bits [4:0] are chr_off)
//   map_reset     : per-slot reset, 1 = slot held in reset
//   prg_mask      : PRG address AND-mask, (1 << chr_off) - 1
//   chr_base      : CHR address OR-base, 1 << chr_off
//   cfg_err       : the most recent request named a slot that does not exist
// -----------------------------------------------------------------------------
module map_switch #(
    parameter int MAP_CNT     = 32,
    parameter int ADDR_BITS   = 23,
    parameter int ARGS_BITS   = 7,
    parameter int HOLD_CYCLES = 8,
    parameter int SEL_BITS    = $clog2(MAP_CNT)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ARGS_BITS+SEL_BITS-1:0] map_ctrl,
    input  logic                          map_ctrl_req,
    output logic                          map_ctrl_ack,
    input  logic                          bus_busy,
    output logic [SEL_BITS-1:0]           select,
    output logic [ARGS_BITS-1:0]          map_args,
    output logic [MAP_CNT-1:0]            map_reset,
    output logic [ADDR_BITS-1:0]          prg_mask,
    output logic [ADDR_BITS-1:0]          chr_base,
    output logic                          cfg_err
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // One extra bit so the slot-count comparison is meaningful even when
    // MAP_CNT is a power of two (every encodable select is then valid).
    localparam logic [SEL_BITS:0] MAP_CNT_EXT = MAP_CNT[SEL_BITS:0];
    localparam logic [7:0]        HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    logic [1:0]                   sync_reg;
    logic [1:0]                   state_reg;
    logic [ARGS_BITS+SEL_BITS-1:0] shadow_reg;
    logic                         idle_seen_reg;
    logic [7:0]                   hold_cnt_reg;
    logic [SEL_BITS-1:0]          select_reg;
    logic [ARGS_BITS-1:0]         args_reg;
    logic [ADDR_BITS-1:0]         mask_reg;
    logic [ADDR_BITS-1:0]         base_reg;
    logic                         ack_reg;
    logic                         err_reg;

    logic                         pending;
    logic [SEL_BITS-1:0]          shadow_sel;
    logic [ARGS_BITS-1:0]         shadow_args;
    logic [4:0]                   chr_off_next;
    logic                         shadow_oob;
    logic [ADDR_BITS-1:0]         mask_next;
    logic [ADDR_BITS-1:0]         base_next;
    logic [SEL_BITS-1:0]          released_sel;
    logic                         in_hold;

    // A request is outstanding whenever the synchronized toggle differs from
    // the acknowledge; a toggle seen while busy stays latched this way.
    assign pending      = sync_reg[1] != ack_reg;

    assign shadow_sel   = shadow_reg[SEL_BITS-1:0];
    assign shadow_args  = shadow_reg[ARGS_BITS+SEL_BITS-1:SEL_BITS];
    assign chr_off_next = shadow_args[4:0];
    assign shadow_oob   = {1'b0, shadow_sel} >= MAP_CNT_EXT;

    // Mask bit gi is set for every bit below chr_off; the base is the single
    // bit at chr_off. A chr_off beyond the address width therefore yields an
    // all-ones mask and a zero base without a separate special case.
    generate
        for (genvar gi = 0; gi < ADDR_BITS; gi++) begin : g_addr
            assign mask_next[gi] = 32'(chr_off_next) > gi;
            assign base_next[gi] = 32'(chr_off_next) == gi;
        end
    endgenerate

    // During COMMIT the new slot is released one cycle ahead of select so the
    // all-ones window lasts exactly the HOLD state.
    assign in_hold      = state_reg == ST_HOLD;
    assign released_sel = (state_reg == ST_COMMIT) ? shadow_sel : select_reg;

    generate
        for (genvar gi = 0; gi < MAP_CNT; gi++) begin : g_slot
            assign map_reset[gi] = in_hold || (released_sel != SEL_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg      <= 2'b00;
            state_reg     <= ST_RUN;
            shadow_reg    <= '0;
            idle_seen_reg <= 1'b0;
            hold_cnt_reg  <= 8'd0;
            select_reg    <= '0;
            args_reg      <= '0;
            mask_reg      <= '0;
            base_reg      <= ADDR_BITS'(1);
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], map_ctrl_req};
            case (state_reg)
                ST_RUN: begin
                    if (pending) begin
                        shadow_reg    <= map_ctrl;
                        idle_seen_reg <= 1'b0;
                        state_reg     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (shadow_oob) begin
                        // Reject without touching the running mapper.
                        err_reg   <= 1'b1;
                        ack_reg   <= ~ack_reg;
                        state_reg <= ST_RUN;
                    end else if (bus_busy) begin
                        idle_seen_reg <= 1'b0;
                    end else if (idle_seen_reg) begin
                        hold_cnt_reg <= HOLD_LOAD;
                        state_reg    <= ST_HOLD;
                    end else begin
                        idle_seen_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_reg == 8'd0) begin
                        state_reg <= ST_COMMIT;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 8'd1;
                    end
                end
                ST_COMMIT: begin
                    select_reg <= shadow_sel;
                    args_reg   <= shadow_args;
                    mask_reg   <= mask_next;
                    base_reg   <= base_next;
                    err_reg    <= 1'b0;
                    // Taking the synchronized level rather than inverting lets
                    // a request that toggled back meanwhile cancel out.
                    ack_reg    <= sync_reg[1];
                    state_reg  <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign map_ctrl_ack = ack_reg;
    assign select       = select_reg;
    assign map_args     = args_reg;
    assign prg_mask     = mask_reg;
    assign chr_base     = base_reg;
    assign cfg_err      = err_reg;

endmodule

// File: tb/tb_map_switch.sv
module tb_map_switch;

    localparam int MAP_CNT   = 24;
    localparam int ADDR_BITS = 23;
    localparam int ARGS_BITS = 7;
    localparam int HOLD      = 8;
    localparam int SEL_BITS  = $clog2(MAP_CNT);

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b0;
    logic [ARGS_BITS+SEL_BITS-1:0] map_ctrl = '0;
    logic                          map_ctrl_req = 1'b0;
    logic                          map_ctrl_ack;
    logic                          bus_busy = 1'b0;
    logic [SEL_BITS-1:0]           select;
    logic [ARGS_BITS-1:0]          map_args;
    logic [MAP_CNT-1:0]            map_reset;
    logic [ADDR_BITS-1:0]          prg_mask;
    logic [ADDR_BITS-1:0]          chr_base;
    logic                          cfg_err;

    map_switch #(
        .MAP_CNT    (MAP_CNT),
        .ADDR_BITS  (ADDR_BITS),
        .ARGS_BITS  (ARGS_BITS),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .map_ctrl    (map_ctrl),
        .map_ctrl_req(map_ctrl_req),
        .map_ctrl_ack(map_ctrl_ack),
        .bus_busy    (bus_busy),
        .select      (select),
        .map_args    (map_args),
        .map_reset   (map_reset),
        .prg_mask    (prg_mask),
        .chr_base    (chr_base),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEL_BITS-1:0]  sel;
        logic [ARGS_BITS-1:0] args;
        logic [ADDR_BITS-1:0] mask;
        logic [ADDR_BITS-1:0] base;
        logic                 err;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;
    logic rand_busy = 1'b0;

    // Reference model of the committed configuration
    logic [SEL_BITS-1:0]  m_sel;
    logic [ARGS_BITS-1:0] m_args;
    logic [ADDR_BITS-1:0] m_mask;
    logic [ADDR_BITS-1:0] m_base;
    logic                 m_err;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endfunction

    function automatic logic [ADDR_BITS-1:0] exp_mask(int off);
        logic [63:0] m;
        if (off >= ADDR_BITS) m = '1;
        else m = (64'd1 << off) - 64'd1;
        return m[ADDR_BITS-1:0];
    endfunction

    function automatic logic [ADDR_BITS-1:0] exp_base(int off);
        logic [63:0] b;
        if (off >= ADDR_BITS) b = 64'd0;
        else b = 64'd1 << off;
        return b[ADDR_BITS-1:0];
    endfunction

    function automatic logic [MAP_CNT-1:0] released_vec(int sel);
        logic [MAP_CNT-1:0] v;
        v = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_sel  = '0;
        m_args = '0;
        m_mask = exp_mask(0);
        m_base = exp_base(0);
        m_err  = 1'b0;
    endtask

    // Predict the outcome, queue it for the monitor, then toggle the request.
    task automatic push_req(input int sel, input int args, output logic valid);
        exp_t e;
        valid = sel < MAP_CNT;
        if (valid) begin
            m_sel  = SEL_BITS'(sel);
            m_args = ARGS_BITS'(args);
            m_mask = exp_mask(args % 32);
            m_base = exp_base(args % 32);
            m_err  = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        e.sel = m_sel; e.args = m_args; e.mask = m_mask; e.base = m_base; e.err = m_err;
        exp_q.push_back(e);
        map_ctrl     = {ARGS_BITS'(args), SEL_BITS'(sel)};
        map_ctrl_req = ~map_ctrl_req;
    endtask

    task automatic wait_switch(input logic old_ack, input int budget,
                               output int edges, output int ones);
        edges = 0;
        ones  = 0;
        while (map_ctrl_ack == old_ack && edges < budget) begin
            if (rand_busy) bus_busy = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            edges++;
            if (map_reset == '1) ones++;
        end
        if (map_ctrl_ack == old_ack) check("ack_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_req(input int sel, input int args, input logic check_lat);
        logic old_ack;
        logic valid;
        int edges, ones;
        old_ack = map_ctrl_ack;
        push_req(sel, args, valid);
        wait_switch(old_ack, 400, edges, ones);
        if (check_lat) begin
            if (valid) check("latency", 64'(edges), 64'(HOLD + 6));
            else       check("err_ack_within", 64'(edges <= 6), 64'd1);
        end
        check("hold_cycles", 64'(ones), valid ? 64'(HOLD) : 64'd0);
        check("map_reset_run", 64'(map_reset), 64'(released_vec(m_sel)));
    endtask

    // Monitor: every acknowledge edge is matched against the oldest prediction.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_ack = map_ctrl_ack;
            end else if (map_ctrl_ack !== prev_ack) begin
                prev_ack = map_ctrl_ack;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_select", 64'(select), 64'(e.sel));
                    check("mon_args", 64'(map_args), 64'(e.args));
                    check("mon_prg_mask", 64'(prg_mask), 64'(e.mask));
                    check("mon_chr_base", 64'(chr_base), 64'(e.base));
                    check("mon_cfg_err", 64'(cfg_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(string tag);
        check({tag, "_select"}, 64'(select), 64'd0);
        check({tag, "_args"}, 64'(map_args), 64'd0);
        check({tag, "_map_reset"}, 64'(map_reset), 64'(released_vec(0)));
        check({tag, "_prg_mask"}, 64'(prg_mask), 64'd0);
        check({tag, "_chr_base"}, 64'(chr_base), 64'd1);
        check({tag, "_ack"}, 64'(map_ctrl_ack), 64'd0);
        check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    endtask

    initial begin
        logic old_ack, old2, valid;
        logic [MAP_CNT-1:0] old_rst;
        int edges, ones, bad, sel;

        model_reset();
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_values("reset");
        @(negedge clk); #1 mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic switch to slot 2, chr_off 5
        do_req(2, 5, 1'b1);
        check("basic_select", 64'(select), 64'd2);
        check("basic_prg_mask", 64'(prg_mask), 64'h1F);
        check("basic_chr_base", 64'(chr_base), 64'h20);
        do_req(10, $urandom_range(0, 127), 1'b1);

        // Bus busy for 20 cycles: stall in DRAIN with the old mapper running
        old_rst = released_vec(m_sel);
        bus_busy = 1'b1;
        old_ack = map_ctrl_ack;
        push_req(5, 9, valid);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (map_ctrl_ack !== old_ack || map_reset !== old_rst) bad++;
        end
        check("busy_stall_bad_cycles", 64'(bad), 64'd0);
        bus_busy = 1'b0;
        wait_switch(old_ack, 100, edges, ones);
        check("busy_release_latency", 64'(edges), 64'(HOLD + 3));
        check("busy_hold_cycles", 64'(ones), 64'(HOLD));

        // Out-of-range slot, then a valid request clears the error
        do_req(MAP_CNT, 3, 1'b1);
        check("cfg_err_set", 64'(cfg_err), 64'd1);
        do_req(4, 12, 1'b1);
        check("cfg_err_clear", 64'(cfg_err), 64'd0);

        // chr_off beyond the address width
        do_req(6, 7'h5F, 1'b1);
        check("chr31_prg_mask", 64'(prg_mask), 64'h7FFFFF);
        check("chr31_chr_base", 64'(chr_base), 64'd0);

        // Second toggle in the last HOLD cycle is serviced right after RUN
        old_ack = map_ctrl_ack;
        push_req(3, 17, valid);
        ones = 0;
        edges = 0;
        while (ones < HOLD && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (map_reset == '1) ones++;
        end
        check("hold_reached", 64'(ones), 64'(HOLD));
        push_req(7, 40, valid);
        wait_switch(old_ack, 100, edges, ones);
        old2 = map_ctrl_ack;
        wait_switch(old2, 100, edges, ones);
        check("second_latency", 64'(edges), 64'(HOLD + 4));
        check("second_hold_cycles", 64'(ones), 64'(HOLD));
        check("second_parity", 64'(map_ctrl_ack), 64'(map_ctrl_req));
        @(negedge clk); #1;
        check("second_select", 64'(select), 64'd7);

        // Reset pulse in the middle of HOLD aborts the switch
        @(posedge clk); #1;
        push_req(9, 22, valid);
        ones = 0;
        edges = 0;
        while (ones < 3 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (map_reset == '1) ones++;
        end
        check("midhold_reached", 64'(ones), 64'd3);
        mon_en = 1'b0;
        reset_n = 1'b0;
        map_ctrl_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        model_reset();
        check_reset_values("midhold_reset");
        @(negedge clk); #1 mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_ack", 64'(map_ctrl_ack), 64'd0);
        check("post_reset_select", 64'(select), 64'd0);

        // Randomized requests with a randomly busy bus
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) sel = $urandom_range(MAP_CNT, (1 << SEL_BITS) - 1);
            else sel = $urandom_range(0, MAP_CNT - 1);
            do_req(sel, $urandom_range(0, 127), 1'b0);
        end
        rand_busy = 1'b0;
        bus_busy = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_parity", 64'(map_ctrl_ack), 64'(map_ctrl_req));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/map_switch.md
MAP_SWITCH -- requirements
Module: map_switch

Parameters
REQ-001 SHALL provide MAP_CNT, default 32: number of mapper slots, range 2..64.
REQ-002 SHALL provide ADDR_BITS, default 23: SDRAM address width plus 1.
REQ-003 SHALL provide ARGS_BITS, default 7: mapper argument width; bits [4:0] are chr_off.
REQ-004 SHALL provide HOLD_CYCLES, default 8: reset-hold length in clk cycles, range 1..255.
REQ-005 SHALL derive SEL_BITS = clog2(MAP_CNT).

Interface
REQ-006 clk  in  1: single clock; all logic SHALL run on the rising edge.
REQ-007 reset_n  in  1: reset, synchronous, active-low.
REQ-008 map_ctrl  in  ARGS_BITS+SEL_BITS: {args, select}; stable while a request is pending.
REQ-009 map_ctrl_req  in  1: toggle request from another clock domain.
REQ-010 map_ctrl_ack  out  1: toggle acknowledge.
REQ-011 bus_busy  in  1: selected mapper has prg_oe or chr_ce active.
REQ-012 select  out  SEL_BITS: active mapper index.
REQ-013 map_args  out  ARGS_BITS: active mapper arguments.
REQ-014 map_reset  out  MAP_CNT: per-slot reset, 1 = held in reset.
REQ-015 prg_mask  out  ADDR_BITS: PRG address AND-mask.
REQ-016 chr_base  out  ADDR_BITS: CHR address OR-base.
REQ-017 cfg_err  out  1: last request was rejected.

Function
REQ-018 map_ctrl_req SHALL pass through a 2-flop synchronizer; the request is pending when sync[1] != map_ctrl_ack.
REQ-019 FSM states SHALL be RUN, DRAIN, HOLD, COMMIT.
- RUN -> DRAIN when a request is pending.
REQ-020 On entering DRAIN, map_ctrl SHALL be captured into a shadow register.
- An out-of-range select (>= MAP_CNT) SHALL set cfg_err=1, toggle the ack, and return to RUN.
- select, map_args and map_reset SHALL be unchanged in that case.
REQ-021 DRAIN SHALL wait until bus_busy=0 on 2 consecutive cycles, then go to HOLD.
- A counter SHALL be loaded with HOLD_CYCLES-1.
REQ-022 In HOLD, map_reset SHALL be all ones; the counter decrements each cycle.
- At 0 the FSM goes to COMMIT.
REQ-023 In COMMIT (1 cycle), the FSM SHALL:
- load select and map_args from the shadow register;
- recompute prg_mask and chr_base;
- clear cfg_err;
- set map_ctrl_ack = sync[1];
- go to RUN.
REQ-024 In RUN and DRAIN, map_reset[n] SHALL be 0 only for n == select; every other bit is 1.
REQ-025 prg_mask SHALL equal (1 << chr_off) - 1, truncated to ADDR_BITS.
REQ-026 chr_base SHALL equal 1 << chr_off, truncated to ADDR_BITS.
REQ-027 If chr_off >= ADDR_BITS, prg_mask SHALL be all ones and chr_base SHALL be 0.
REQ-028 prg_mask and chr_base SHALL be registered; they change only in COMMIT or reset.
REQ-029 A request toggle arriving while not in RUN SHALL be latched by the mismatch.
- It is serviced after returning to RUN; no request is lost.
- Requests that toggle twice before being serviced SHALL merge into none.
REQ-030 Ack-to-RUN latency from a pending request with bus idle SHALL be 2 + HOLD_CYCLES + 1 cycles.
REQ-031 bus_busy stuck at 1 SHALL keep the FSM in DRAIN indefinitely.
- The old mapper stays out of reset in that case.

Reset
REQ-032 While reset_n=0 at a clk edge, the block SHALL set:
- FSM = RUN, select = 0, map_args = 0;
- map_reset = all ones except bit 0;
- prg_mask = 0 (chr_off 0), chr_base = 1;
- map_ctrl_ack = 0, cfg_err = 0, synchronizer = 0, counter = 0.
REQ-033 Reset asserted in any state SHALL abort the switch at the next edge; the shadow register is discarded.

Verification
REQ-034 After reset, toggle req with map_ctrl={args=5, select=2} and bus_busy=0:
- ack toggles at the COMMIT edge;
- select=2, prg_mask=0x1F, chr_base=0x20;
- map_reset was all ones for exactly HOLD_CYCLES cycles.
REQ-035 Hold bus_busy=1 for 20 cycles during a request:
- FSM stays in DRAIN, old mapper stays released, ack does not toggle;
- after release, the switch completes with the REQ-030 latency.
REQ-036 Request select=MAP_CNT:
- cfg_err=1 and ack toggles within 4 cycles;
- select and map_reset are unchanged.
- A following valid request clears cfg_err.
REQ-037 Assert reset_n=0 for 1 cycle mid-HOLD:
- the next cycle shows the REQ-032 values with select=0;
- map_ctrl_ack=0.
REQ-038 Request args with chr_off=31 at ADDR_BITS=23 -> prg_mask=0x7FFFFF, chr_base=0.
REQ-039 Issue a second toggle during HOLD -> it is serviced immediately after RUN is re-entered; ack parity ends equal to req.
